// File: rtl/instr_control.sv
// Two-phase (FETCH/EXEC) instruction sequencer for an accumulator CPU.
// Define INSTR_CONTROL_COUNT_EN to add the saturating InstrCount output.
module instr_control #(
  parameter int addr_bus  = 11,
  parameter int data_size = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [data_size-1:0] Instr,
  output logic [addr_bus-1:0]  Pc,
  output logic [addr_bus-1:0]  Operand,
  output logic [1:0]           SelA,
  output logic                 SelB,
  output logic                 Op,
  output logic                 WrAcc,
  output logic                 WrRam,
  output logic                 RdRam,
  output logic                 Halted
`ifdef INSTR_CONTROL_COUNT_EN
  ,
  output logic [15:0]          InstrCount
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  localparam logic [addr_bus-1:0] PC_ONE = 1;

  logic [1:0]           state_q, state_d;
  logic [addr_bus-1:0]  pc_q, pc_d;
  logic [data_size-1:0] ir_q, ir_d;
  logic [4:0]           opcode;
  logic                 start_accept;

  assign opcode       = ir_q[data_size-1 -: 5];
  assign start_accept = Start && (state_q == S_IDLE || state_q == S_HALT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (Start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = Instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // HLT keeps Pc pointing at itself so the halt address stays visible.
        if (opcode == OPC_HLT) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_q + PC_ONE;
          state_d = S_FETCH;
        end
      end
      default: begin
        if (Start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Strobes decode purely from flops, so they are glitch-free and only live in EXEC.
  always_comb begin
    SelA  = 2'b00;
    SelB  = 1'b0;
    Op    = 1'b0;
    WrAcc = 1'b0;
    WrRam = 1'b0;
    RdRam = 1'b0;
    if (state_q == S_EXEC) begin
      case (opcode)
        OPC_STO: WrRam = 1'b1;
        OPC_LD: begin
          RdRam = 1'b1;
          WrAcc = 1'b1;
        end
        OPC_LDI: begin
          SelA  = 2'b01;
          WrAcc = 1'b1;
        end
        OPC_ADD: begin
          RdRam = 1'b1;
          SelA  = 2'b10;
          WrAcc = 1'b1;
        end
        OPC_ADDI: begin
          SelA  = 2'b10;
          SelB  = 1'b1;
          WrAcc = 1'b1;
        end
        OPC_SUB: begin
          RdRam = 1'b1;
          SelA  = 2'b10;
          Op    = 1'b1;
          WrAcc = 1'b1;
        end
        OPC_SUBI: begin
          SelA  = 2'b10;
          SelB  = 1'b1;
          Op    = 1'b1;
          WrAcc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Pc      = pc_q;
  assign Operand = ir_q[addr_bus-1:0];
  assign Halted  = (state_q == S_HALT);

`ifdef INSTR_CONTROL_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_accept) begin
      cnt_d = '0;
    end else if (state_q == S_EXEC && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign InstrCount = cnt_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_instr_control.sv
// Bench for instr_control: opcode table, directed halt/wrap/reset sequences, random programs.
// Compare InstrCount as well when INSTR_CONTROL_COUNT_EN is defined.
module tb_instr_control;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [15:0] Instr;
  logic [10:0] Pc, Operand;
  logic [1:0]  SelA;
  logic        SelB, Op, WrAcc, WrRam, RdRam, Halted;
`ifdef INSTR_CONTROL_COUNT_EN
  logic [15:0] InstrCount;
`endif

  always #5 Clk = ~Clk;

  instr_control #(.addr_bus(11), .data_size(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr),
    .Pc(Pc), .Operand(Operand), .SelA(SelA), .SelB(SelB), .Op(Op),
    .WrAcc(WrAcc), .WrRam(WrRam), .RdRam(RdRam), .Halted(Halted)
`ifdef INSTR_CONTROL_COUNT_EN
    , .InstrCount(InstrCount)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: phase of the two-cycle instruction cycle plus architectural registers.
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_EXEC = 2, PH_HALT = 3;
  int          m_phase = PH_IDLE;
  int          m_pc = 0;
  logic [15:0] m_ir = '0;
  int          m_cnt = 0;

  logic [15:0] mem [2048];

  // Control word {SelA, SelB, Op, WrAcc, WrRam, RdRam} implied by an opcode.
  function automatic logic [6:0] ctrl_of(input logic [4:0] opc);
    case (opc)
      5'd1:    return 7'b00_0_0_010;
      5'd2:    return 7'b00_0_0_101;
      5'd3:    return 7'b01_0_0_100;
      5'd4:    return 7'b10_0_0_101;
      5'd5:    return 7'b10_1_0_100;
      5'd6:    return 7'b10_0_1_101;
      5'd7:    return 7'b10_1_1_100;
      default: return 7'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (Reset) begin
      m_phase = PH_IDLE; m_pc = 0; m_ir = '0; m_cnt = 0;
    end else begin
      case (m_phase)
        PH_IDLE: if (Start) begin m_phase = PH_FETCH; m_cnt = 0; end
        PH_FETCH: begin m_ir = Instr; m_phase = PH_EXEC; end
        PH_EXEC: begin
          if (m_cnt < 65535) m_cnt++;
          if (m_ir[15:11] == 5'd0) m_phase = PH_HALT;
          else begin m_pc = (m_pc + 1) % 2048; m_phase = PH_FETCH; end
        end
        default: if (Start) begin m_pc = 0; m_phase = PH_FETCH; m_cnt = 0; end
      endcase
    end
  endtask

  task automatic check_all(input string nm);
    logic [31:0] exp_v, act_v;
    logic [6:0]  ctl;
    ctl   = (m_phase == PH_EXEC) ? ctrl_of(m_ir[15:11]) : 7'b0;
    exp_v = {2'b0, m_pc[10:0], m_ir[10:0], ctl, (m_phase == PH_HALT)};
    act_v = {2'b0, Pc, Operand, SelA, SelB, Op, WrAcc, WrRam, RdRam, Halted};
    chk(nm, act_v, exp_v);
`ifdef INSTR_CONTROL_COUNT_EN
    chk({nm, "_cnt"}, {16'b0, InstrCount}, m_cnt);
`endif
  endtask

  // One clock: model advances with the inputs the DUT sees at this edge, compare on the falling edge.
  task automatic cyc(input string nm);
    model_step();
    @(negedge Clk);
    check_all(nm);
  endtask

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [6:0]  exp;
  } vec_t;
  vec_t vt[9];

  initial begin
    vt[0] = '{"LDI16",   16'h1810, 7'b01_0_0_100};
    vt[1] = '{"STO1",    16'h0801, 7'b00_0_0_010};
    vt[2] = '{"LD5",     16'h1005, 7'b00_0_0_101};
    vt[3] = '{"ADD7",    16'h2007, 7'b10_0_0_101};
    vt[4] = '{"ADDI255", 16'h28FF, 7'b10_1_0_100};
    vt[5] = '{"SUB3",    16'h3003, 7'b10_0_1_101};
    vt[6] = '{"SUBI3FF", 16'h3BFF, 7'b10_1_1_100};
    vt[7] = '{"NOPF800", 16'hF800, 7'b00_0_0_000};
    vt[8] = '{"NOP4123", 16'h4123, 7'b00_0_0_000};

    Reset = 1'b1; Start = 1'b0; Instr = '0;
    @(negedge Clk);
    cyc("reset");
    Start = 1'b1;
    cyc("reset_over_start");
    Reset = 1'b0;
    cyc("start_idle");
    Start = 1'b0;

    // Opcode table: each vector is one FETCH + EXEC pair, Pc advancing by one.
    for (int i = 0; i < 9; i++) begin
      Instr = vt[i].instr;
      Start = (i == 2);
      cyc({"fetch_", vt[i].name});
      Start = (i == 3);
      chk({"ctrl_", vt[i].name}, {25'b0, SelA, SelB, Op, WrAcc, WrRam, RdRam}, {25'b0, vt[i].exp});
      chk({"opnd_", vt[i].name}, {21'b0, Operand}, {21'b0, vt[i].instr[10:0]});
      chk({"pc_", vt[i].name}, {21'b0, Pc}, i);
      Instr = 16'($urandom);
      cyc({"exec_", vt[i].name});
    end
    Start = 1'b0;

    // Six NOPs then HLT at Pc=6; hold ten cycles, then restart.
    Reset = 1'b1;
    cyc("reset2");
    Reset = 1'b0; Start = 1'b1;
    cyc("start2");
    Start = 1'b0;
    Instr = 16'hF800;
    repeat (12) cyc("nop6");
    Instr = 16'h0000;
    cyc("hlt_fetch");
    cyc("hlt_exec");
    for (int i = 0; i < 10; i++) begin
      cyc("halt_hold");
      chk("halt_pc", {21'b0, Pc}, 32'd6);
      chk("halt_flag", {31'b0, Halted}, 32'd1);
    end
`ifdef INSTR_CONTROL_COUNT_EN
    chk("count7", {16'b0, InstrCount}, 32'd7);
`endif
    Start = 1'b1;
    cyc("restart");
    Start = 1'b0;
    chk("restart_pc", {21'b0, Pc}, 32'd0);
    chk("restart_halted", {31'b0, Halted}, 32'd0);
`ifdef INSTR_CONTROL_COUNT_EN
    chk("count_clr", {16'b0, InstrCount}, 32'd0);
`endif

    // NOP run to the top of the address space and across the wrap.
    Instr = 16'hF800;
    repeat (2047 * 2) cyc("nop_run");
    chk("pc_top", {21'b0, Pc}, 32'd2047);
    cyc("wrap_fetch");
    cyc("wrap_exec");
    chk("pc_wrap", {21'b0, Pc}, 32'd0);

    // Reset in the middle of an LDI execute.
    Instr = 16'h1810;
    cyc("ldi_fetch");
    chk("ldi_wracc", {31'b0, WrAcc}, 32'd1);
    Reset = 1'b1;
    cyc("rst_mid_exec");
    Reset = 1'b0;
    chk("rst_pc", {21'b0, Pc}, 32'd0);
    chk("rst_strobes", {29'b0, WrAcc, WrRam, RdRam}, 32'd0);

    // Random programs with occasional Start and rare Reset.
    for (int i = 0; i < 2048; i++) begin
      logic [4:0] opc;
      opc = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 9));
      if (opc == 5'd9) opc = 5'($urandom_range(8, 31));
      mem[i] = {opc, 11'($urandom)};
    end
    for (int i = 0; i < 3000; i++) begin
      Instr = mem[Pc];
      Start = ($urandom_range(0, 5) == 0);
      Reset = ($urandom_range(0, 199) == 0);
      cyc("rand");
    end
    Reset = 1'b0; Start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_control.md
INSTR_CONTROL -- requirements
Module: instr_control

Interface
REQ-001 Parameter addr_bus, 11, program address width (Pc, Operand).
REQ-002 Parameter data_size, 16, instruction width; opcode = top 5 bits, operand = low addr_bus bits.
REQ-003 Clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Start  in  1  begin execution from IDLE or HALT.
REQ-006 Instr  in  data_size  instruction word from program memory, combinationally valid for current Pc.
REQ-007 Pc  out  addr_bus  program counter, drives program memory address.
REQ-008 Operand  out  addr_bus  IR[addr_bus-1:0]: data-memory address or immediate.
REQ-009 SelA  out  2  accumulator source: 00 data memory, 01 immediate, 10 ALU.
REQ-010 SelB  out  1  ALU B operand: 0 data memory, 1 immediate.
REQ-011 Op  out  1  ALU operation: 0 add, 1 subtract.
REQ-012 WrAcc, WrRam, RdRam  out  1 each  accumulator write, data-memory write, data-memory read strobes.
REQ-013 Halted  out  1  high while in HALT.

Function
REQ-014 FSM states IDLE, FETCH, EXEC, HALT; 2-bit state register.
REQ-015 IDLE: Pc=0; Start=1 -> FETCH next edge; else stay.
REQ-016 FETCH: IR <= Instr (at current Pc); -> EXEC next edge; Pc unchanged.
REQ-017 EXEC: decode IR opcode, assert controls for exactly this one cycle; -> FETCH with Pc <= Pc+1, except HLT.
REQ-018 Opcode HLT 00000: no strobes; -> HALT; Pc not incremented.
REQ-019 STO 00001: WrRam=1. LD 00010: RdRam=1, SelA=00, WrAcc=1. LDI 00011: SelA=01, WrAcc=1.
REQ-020 ADD 00100: RdRam=1, SelA=10, SelB=0, Op=0, WrAcc=1. ADDI 00101: SelA=10, SelB=1, Op=0, WrAcc=1.
REQ-021 SUB 00110: RdRam=1, SelA=10, SelB=0, Op=1, WrAcc=1. SUBI 00111: SelA=10, SelB=1, Op=1, WrAcc=1.
REQ-022 Opcodes 01000-11111: treated as NOP; no strobes, Pc increments, -> FETCH.
REQ-023 Outside EXEC: WrAcc=WrRam=RdRam=0, SelA=00, SelB=0, Op=0; outputs derived only from registered state and IR (glitch-free).
REQ-024 Throughput one instruction per 2 cycles; controls appear the cycle after Pc presents the address.
REQ-025 Pc increments modulo 2**addr_bus (2047 -> 0, no flag).
REQ-026 HALT: Halted=1, Pc held; Start=1 -> Pc <= 0, FETCH next edge.
REQ-027 Start ignored in FETCH and EXEC.
REQ-028 Operand continuously reflects IR, including outside EXEC.

Reset
REQ-029 Reset=1 at a rising edge: state=IDLE, Pc=0, IR=0, all strobes 0, Halted=0; overrides Start and any in-flight instruction.
REQ-030 Reset asserted mid-EXEC: the current strobes are asserted at most until that edge; no Pc increment occurs.

Configuration
REQ-031 Macro INSTR_CONTROL_COUNT_EN defined: adds output InstrCount (16 bits), incremented on each EXEC cycle (HLT and NOP included), saturating at 0xFFFF, cleared by Reset and when Start is accepted.
REQ-032 Macro undefined: no InstrCount port or counter logic; all other behaviour identical.

Verification
REQ-033 Reset, Start pulse, Instr=0x1810 (LDI 16) -> FETCH, then EXEC: WrAcc=1, SelA=01, Operand=16; Pc 0->1 at EXEC exit.
REQ-034 Instr=0x0801 (STO 1) -> EXEC: WrRam=1, WrAcc=0, RdRam=0, Operand=1; Instr=0x28FF (ADDI 255) -> SelA=10, SelB=1, Op=0, WrAcc=1.
REQ-035 Instr=0x3003 (SUB 3) -> RdRam=1, SelA=10, SelB=0, Op=1, WrAcc=1; Instr=0xF800 -> no strobes, Pc+1.
REQ-036 HLT (0x0000) at Pc=6 -> Halted=1, Pc stays 6 for 10 cycles, no strobes; Start -> Pc=0, Halted=0, FETCH.
REQ-037 Run NOPs until Pc=2047 -> next increment Pc=0; Reset during EXEC of 0x1810 -> next cycle IDLE, Pc=0, strobes 0.
REQ-038 With INSTR_CONTROL_COUNT_EN: 7-instruction program ending in HLT -> InstrCount=7; Start -> 0.
